// File: rtl/bs_cat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bs_cat_ctrl
// Purpose  : Sequences one zlib stream into the bit-stream concatenator:
//            header, body codes, byte pad, Adler-32, word pad.
// Revision : 1.0 - initial release
// ============================================================================
module bs_cat_ctrl #(
   parameter int DATA_WD = 32,
   parameter int NUMB_WD = 5
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic [15:0]        zhdr_i,
   input  logic               body_val_i,
   input  logic [DATA_WD-1:0] body_dat_i,
   input  logic [NUMB_WD-1:0] body_numb_i,
   input  logic               body_last_i,
   output logic               body_rdy_o,
   input  logic               adler_val_i,
   input  logic [31:0]        adler_i,
   output logic               cat_val_o,
   output logic [DATA_WD-1:0] cat_dat_o,
   output logic [NUMB_WD-1:0] cat_numb_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [31:0]        bit_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BODY  = 3'd1,
      S_ALIGN = 3'd2,
      S_ADLER = 3'd3,
      S_FLUSH = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   state_e               state_q, state_d;
   logic [4:0]           ptr_q, ptr_d;
   logic [31:0]          bit_cnt_q, bit_cnt_d;
   logic                 cat_val_q, cat_val_d;
   logic [DATA_WD-1:0]   cat_dat_q, cat_dat_d;
   logic [NUMB_WD-1:0]   cat_numb_q, cat_numb_d;
   logic [4:0]           ptr_base;
   logic [31:0]          cnt_base;

   always_comb begin
      state_d    = state_q;
      cat_val_d  = 1'b0;
      cat_dat_d  = '0;
      cat_numb_d = '0;
      ptr_base   = ptr_q;
      cnt_base   = bit_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cat_val_d  = 1'b1;
               cat_dat_d  = DATA_WD'(zhdr_i);
               cat_numb_d = NUMB_WD'(15);
               ptr_base   = '0;
               cnt_base   = '0;
               state_d    = S_BODY;
            end
         end
         S_BODY: begin
            if (body_val_i) begin
               cat_val_d  = 1'b1;
               cat_dat_d  = body_dat_i;
               cat_numb_d = body_numb_i;
               if (body_last_i) state_d = S_ALIGN;
            end
         end
         S_ALIGN: begin
            // Pad with zeros up to the next byte boundary.
            if (ptr_q[2:0] != 3'd0) begin
               cat_val_d  = 1'b1;
               cat_numb_d = NUMB_WD'(3'd7 - ptr_q[2:0]);
            end
            state_d = S_ADLER;
         end
         S_ADLER: begin
            if (adler_val_i) begin
               cat_val_d  = 1'b1;
               cat_dat_d  = DATA_WD'(adler_i);
               cat_numb_d = NUMB_WD'(31);
               state_d    = S_FLUSH;
            end
         end
         S_FLUSH: begin
            // Zero pad to a word boundary so the concatenator flushes its last word.
            if (ptr_q != 5'd0) begin
               cat_val_d  = 1'b1;
               cat_numb_d = NUMB_WD'(5'd31 - ptr_q);
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      ptr_d     = cat_val_d ? (ptr_base + 5'(cat_numb_d) + 5'd1) : ptr_base;
      bit_cnt_d = cat_val_d ? (cnt_base + 32'(cat_numb_d) + 32'd1) : cnt_base;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         bit_cnt_q  <= '0;
         cat_val_q  <= 1'b0;
         cat_dat_q  <= '0;
         cat_numb_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         bit_cnt_q  <= bit_cnt_d;
         cat_val_q  <= cat_val_d;
         cat_dat_q  <= cat_dat_d;
         cat_numb_q <= cat_numb_d;
      end
   end

   assign body_rdy_o = (state_q == S_BODY);
   assign busy_o     = (state_q != S_IDLE);
   assign done_o     = (state_q == S_DONE);
   assign cat_val_o  = cat_val_q;
   assign cat_dat_o  = cat_dat_q;
   assign cat_numb_o = cat_numb_q;
   assign bit_cnt_o  = bit_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bs_cat_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bs_cat_ctrl
// Purpose  : Self-checking bench for bs_cat_ctrl against a bit-count stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bs_cat_ctrl;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] zhdr_i = '0;
   logic        body_val_i = 1'b0;
   logic [31:0] body_dat_i = '0;
   logic [4:0]  body_numb_i = '0;
   logic        body_last_i = 1'b0;
   logic        body_rdy_o;
   logic        adler_val_i = 1'b0;
   logic [31:0] adler_i = '0;
   logic        cat_val_o;
   logic [31:0] cat_dat_o;
   logic [4:0]  cat_numb_o;
   logic        busy_o;
   logic        done_o;
   logic [31:0] bit_cnt_o;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;

   logic [36:0] obs_q[$];
   logic [36:0] exp_q[$];
   logic [31:0] code_dat[64];
   logic [4:0]  code_numb[64];
   int          n_codes;

   always #5 clk = ~clk;

   bs_cat_ctrl #(.DATA_WD(32), .NUMB_WD(5)) dut (
      .clk(clk), .rstn(rstn), .start_i(start_i), .zhdr_i(zhdr_i),
      .body_val_i(body_val_i), .body_dat_i(body_dat_i), .body_numb_i(body_numb_i),
      .body_last_i(body_last_i), .body_rdy_o(body_rdy_o),
      .adler_val_i(adler_val_i), .adler_i(adler_i),
      .cat_val_o(cat_val_o), .cat_dat_o(cat_dat_o), .cat_numb_o(cat_numb_o),
      .busy_o(busy_o), .done_o(done_o), .bit_cnt_o(bit_cnt_o)
   );

   // Capture every concatenator write and done pulse away from the active edge.
   always @(negedge clk) begin
      if (rstn) begin
         if (cat_val_o) obs_q.push_back({cat_numb_o, cat_dat_o});
         if (done_o) done_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Stream model: header, codes, pad to byte, Adler, pad to 32-bit word.
   function automatic int build_expect(input logic [15:0] hdr, input logic [31:0] adl);
      int bits;
      int pad;
      exp_q.delete();
      exp_q.push_back({5'd15, 16'h0, hdr});
      bits = 16;
      for (int i = 0; i < n_codes; i++) begin
         exp_q.push_back({code_numb[i], code_dat[i]});
         bits += int'(code_numb[i]) + 1;
      end
      pad = (8 - (bits % 8)) % 8;
      if (pad != 0) exp_q.push_back({5'(pad - 1), 32'h0});
      bits += pad;
      exp_q.push_back({5'd31, adl});
      bits += 32;
      pad = (32 - (bits % 32)) % 32;
      if (pad != 0) exp_q.push_back({5'(pad - 1), 32'h0});
      bits += pad;
      return bits;
   endfunction

   function automatic int obs_bits();
      int s = 0;
      foreach (obs_q[i]) s += int'(obs_q[i][36:32]) + 1;
      return s;
   endfunction

   task automatic run_stream(input logic [15:0] hdr, input logic [31:0] adl,
                             input bit gap, input int dly, input bit chk_lat);
      int  bits;
      int  g;
      int  cyc;
      bit  r;
      bit  got;
      logic [63:0] mask;
      bits = build_expect(hdr, adl);
      obs_q.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start_i = 1'b1; zhdr_i = hdr;
      @(posedge clk); #1;
      start_i = 1'b0;
      for (int i = 0; i < n_codes; i++) begin
         if (gap && i > 0) begin
            body_val_i = 1'b0;
            start_i    = 1'b1;
            @(posedge clk); #1;
            start_i    = 1'b0;
         end
         body_val_i  = 1'b1;
         body_dat_i  = code_dat[i];
         body_numb_i = code_numb[i];
         body_last_i = (i == n_codes - 1);
         g = 0;
         do begin
            @(negedge clk); r = body_rdy_o;
            @(posedge clk); #1;
            g++;
         end while (!r && g < 20);
         if (!r) chk("body_rdy_timeout", 64'(r), 64'd1);
      end
      body_val_i = 1'b0; body_last_i = 1'b0;
      body_dat_i = $urandom;
      adler_i = adl;
      if (dly == 0) begin
         adler_val_i = 1'b1;
      end else begin
         @(posedge clk); #1;
         @(posedge clk); #1;
         for (int j = 0; j < dly; j++) begin
            @(negedge clk);
            chk("stall_cat_val", 64'(cat_val_o), 64'd0);
            chk("stall_busy", 64'(busy_o), 64'd1);
            @(posedge clk); #1;
         end
         adler_val_i = 1'b1;
      end
      cyc = 0; got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (done_o) got = 1'b1;
      end
      chk("done_seen", 64'(got), 64'd1);
      if (chk_lat) chk("done_latency", 64'(cyc), 64'd4);
      chk("bit_cnt", 64'(bit_cnt_o), 64'(bits));
      adler_val_i = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_after_done", 64'(busy_o), 64'd0);
      chk("done_pulses", 64'(done_cnt), 64'd1);
      chk("n_writes", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         mask = (64'd1 << (int'(exp_q[i][36:32]) + 1)) - 64'd1;
         chk("wr_numb", 64'(obs_q[i][36:32]), 64'(exp_q[i][36:32]));
         chk("wr_data", 64'(obs_q[i][31:0]) & mask, 64'(exp_q[i][31:0]) & mask);
      end
   endtask

   initial begin
      // Power-on reset
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cat_val", 64'(cat_val_o), 64'd0);
      chk("rst_busy", 64'(busy_o), 64'd0);
      chk("rst_rdy", 64'(body_rdy_o), 64'd0);
      @(negedge clk); rstn = 1'b1;

      // body_val_i in IDLE is not accepted
      obs_q.delete();
      @(posedge clk); #1;
      body_val_i = 1'b1; body_dat_i = 32'h1234; body_numb_i = 5'd7;
      repeat (3) begin
         @(negedge clk);
         chk("idle_rdy", 64'(body_rdy_o), 64'd0);
         chk("idle_cat_val", 64'(cat_val_o), 64'd0);
      end
      body_val_i = 1'b0;

      // Minimal stream
      n_codes = 1; code_dat[0] = 32'h3; code_numb[0] = 5'd2;
      run_stream(16'h789C, 32'h00000001, 1'b0, 0, 1'b1);
      chk("min_words", 64'(obs_bits() / 32), 64'd2);

      // Aligned body: no pads
      n_codes = 2;
      code_dat[0] = 32'hA5; code_numb[0] = 5'd7;
      code_dat[1] = 32'h5A; code_numb[1] = 5'd7;
      run_stream(16'h789C, 32'hDEADBEEF, 1'b0, 0, 1'b1);

      // Gaps with ignored start pulses
      n_codes = 4;
      for (int i = 0; i < 4; i++) begin
         code_dat[i] = $urandom; code_numb[i] = 5'($urandom_range(0, 31));
      end
      run_stream(16'h7801, $urandom, 1'b1, 0, 1'b1);

      // Adler stall
      n_codes = 3;
      for (int i = 0; i < 3; i++) begin
         code_dat[i] = $urandom; code_numb[i] = 5'($urandom_range(0, 31));
      end
      run_stream(16'h78DA, $urandom, 1'b0, 10, 1'b0);

      // Maximum-length codes
      n_codes = 40;
      for (int i = 0; i < 40; i++) begin
         code_dat[i] = 32'hFFFFFFFF; code_numb[i] = 5'd31;
      end
      run_stream(16'h789C, 32'h0BADF00D, 1'b0, 0, 1'b1);

      // Randomized streams
      for (int s = 0; s < 8; s++) begin
         n_codes = $urandom_range(1, 12);
         for (int i = 0; i < n_codes; i++) begin
            code_dat[i] = $urandom; code_numb[i] = 5'($urandom_range(0, 31));
         end
         run_stream(16'($urandom), $urandom, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), 1'b0);
      end

      // Asynchronous reset mid-BODY
      @(posedge clk); #1;
      start_i = 1'b1; zhdr_i = 16'h789C;
      @(posedge clk); #1;
      start_i = 1'b0;
      body_val_i = 1'b1; body_dat_i = 32'hCAFE; body_numb_i = 5'd15; body_last_i = 1'b0;
      @(posedge clk); #3;
      rstn = 1'b0;
      #1;
      chk("arst_cat_val", 64'(cat_val_o), 64'd0);
      chk("arst_cat_dat", 64'(cat_dat_o), 64'd0);
      chk("arst_cat_numb", 64'(cat_numb_o), 64'd0);
      chk("arst_bit_cnt", 64'(bit_cnt_o), 64'd0);
      chk("arst_done", 64'(done_o), 64'd0);
      chk("arst_busy", 64'(busy_o), 64'd0);
      chk("arst_rdy", 64'(body_rdy_o), 64'd0);
      @(negedge clk); rstn = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_cat_val", 64'(cat_val_o), 64'd0);
         chk("post_rst_busy", 64'(busy_o), 64'd0);
      end
      body_val_i = 1'b0;

      // Controller is usable again after reset
      n_codes = 2;
      code_dat[0] = 32'h1; code_numb[0] = 5'd0;
      code_dat[1] = 32'h7F; code_numb[1] = 5'd6;
      run_stream(16'h789C, 32'h12345678, 1'b0, 0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
